// File: rtl/generic_bus_arbiter_if.sv
// Generic-bus port bundle: address/strobes/write data travel master->slave,
// read data and busy travel back.
interface generic_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ren;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    modport master (
        output addr, ren, wen, wdata, byte_en,
        input  rdata, busy
    );

    modport slave (
        input  addr, ren, wen, wdata, byte_en,
        output rdata, busy
    );
endinterface

// File: rtl/generic_bus_arbiter.sv
// Two-requester round-robin arbiter in front of one generic-bus slave.
// Ownership is held until the slave completes or the owner drops its request.
module generic_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    generic_bus_arbiter_if.slave  m0,
    generic_bus_arbiter_if.slave  m1,
    generic_bus_arbiter_if.master s,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_rr;
    logic                  w_next_rr;
    logic                  w_req0;
    logic                  w_req1;
    logic [ADDR_WIDTH-1:0] w_s_addr;
    logic [DATA_WIDTH-1:0] w_s_wdata;
    logic [DATA_WIDTH-1:0] w_m0_rdata;
    logic [DATA_WIDTH-1:0] w_m1_rdata;

    assign w_req0 = m0.ren | m0.wen;
    assign w_req1 = m1.ren | m1.wen;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_rr    <= w_next_rr;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_rr    = r_rr;
        w_s_addr     = '0;
        w_s_wdata    = '0;
        s.ren        = 1'b0;
        s.wen        = 1'b0;
        s.byte_en    = 4'h0;
        w_m0_rdata   = '0;
        w_m1_rdata   = '0;
        m0.busy      = 1'b1;
        m1.busy      = 1'b1;
        grant        = 2'b00;

        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next_state = r_rr ? GRANT1 : GRANT0;
                end else if (w_req0) begin
                    w_next_state = GRANT0;
                end else if (w_req1) begin
                    w_next_state = GRANT1;
                end
            end

            GRANT0: begin
                w_s_addr   = m0.addr;
                w_s_wdata  = m0.wdata;
                s.ren      = m0.ren;
                s.wen      = m0.wen;
                s.byte_en  = m0.byte_en;
                w_m0_rdata = s.rdata;
                m0.busy    = s.busy;
                grant      = 2'b01;
                if (!w_req0) begin
                    w_next_state = IDLE;
                end else if (!s.busy) begin
                    w_next_state = IDLE;
                    w_next_rr    = 1'b1;
                end
            end

            GRANT1: begin
                w_s_addr   = m1.addr;
                w_s_wdata  = m1.wdata;
                s.ren      = m1.ren;
                s.wen      = m1.wen;
                s.byte_en  = m1.byte_en;
                w_m1_rdata = s.rdata;
                m1.busy    = s.busy;
                grant      = 2'b10;
                if (!w_req1) begin
                    w_next_state = IDLE;
                end else if (!s.busy) begin
                    w_next_state = IDLE;
                    w_next_rr    = 1'b0;
                end
            end

            default: w_next_state = IDLE;
        endcase
    end

    assign s.addr   = w_s_addr;
    assign s.wdata  = w_s_wdata;
    assign m0.rdata = w_m0_rdata;
    assign m1.rdata = w_m1_rdata;

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Bench for generic_bus_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level ownership model.
module tb_generic_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [1:0] grant;

    generic_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    generic_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    generic_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

    generic_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .grant (grant)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]    grant;
        logic          m0_busy;
        logic          m1_busy;
        logic [DW-1:0] m0_rdata;
        logic [DW-1:0] m1_rdata;
        logic          s_ren;
        logic          s_wen;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        logic [3:0]    s_byte_en;
    } obs_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t obs;
    obs_t exp;

    // Model: who owns the slave (-1 = nobody) and who wins the next tie.
    int m_owner = -1;
    int m_pref  = 0;

    function automatic obs_t observe();
        obs_t o;
        o.grant     = grant;
        o.m0_busy   = m0_if.busy;
        o.m1_busy   = m1_if.busy;
        o.m0_rdata  = m0_if.rdata;
        o.m1_rdata  = m1_if.rdata;
        o.s_ren     = s_if.ren;
        o.s_wen     = s_if.wen;
        o.s_addr    = s_if.addr;
        o.s_wdata   = s_if.wdata;
        o.s_byte_en = s_if.byte_en;
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t e;
        e = '0;
        e.m0_busy = 1'b1;
        e.m1_busy = 1'b1;
        if (m_owner == 0) begin
            e.grant     = 2'b01;
            e.s_ren     = m0_if.ren;
            e.s_wen     = m0_if.wen;
            e.s_addr    = m0_if.addr;
            e.s_wdata   = m0_if.wdata;
            e.s_byte_en = m0_if.byte_en;
            e.m0_rdata  = s_if.rdata;
            e.m0_busy   = s_if.busy;
        end else if (m_owner == 1) begin
            e.grant     = 2'b10;
            e.s_ren     = m1_if.ren;
            e.s_wen     = m1_if.wen;
            e.s_addr    = m1_if.addr;
            e.s_wdata   = m1_if.wdata;
            e.s_byte_en = m1_if.byte_en;
            e.m1_rdata  = s_if.rdata;
            e.m1_busy   = s_if.busy;
        end
        return e;
    endfunction

    task automatic model_step();
        bit r0, r1, own_req;
        r0 = m0_if.ren | m0_if.wen;
        r1 = m1_if.ren | m1_if.wen;
        if (m_owner < 0) begin
            if (r0 && r1) m_owner = m_pref;
            else if (r0)  m_owner = 0;
            else if (r1)  m_owner = 1;
        end else begin
            own_req = (m_owner == 0) ? r0 : r1;
            if (!own_req) begin
                m_owner = -1;
            end else if (!s_if.busy) begin
                m_pref  = 1 - m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_pref  = 0;
    endtask

    // One clock: model advances on the edge, inputs change after the falling edge.
    task automatic tick();
        @(posedge CLK);
        if (nRST) model_step();
        else      model_reset();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        m0_if.addr = '0; m0_if.ren = 0; m0_if.wen = 0; m0_if.wdata = '0; m0_if.byte_en = 4'h0;
        m1_if.addr = '0; m1_if.ren = 0; m1_if.wen = 0; m1_if.wdata = '0; m1_if.byte_en = 4'h0;
        s_if.rdata = '0; s_if.busy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        model_reset();
        clear_inputs();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        model_reset();
        @(negedge CLK);
        m0_if.ren = 1; m0_if.addr = 32'h100;
        m1_if.wen = 1; m1_if.addr = 32'h200;
        s_if.rdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            #1;
            obs = observe(); exp = model_out(); n_checks++;
            if (obs !== exp)
                $display("FAIL reset_model c%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            n_checks++;
            if (grant !== 2'b00 || m0_if.busy !== 1'b1 || m1_if.busy !== 1'b1 || s_if.ren !== 1'b0)
                $display("FAIL reset_idle c%0d: got grant=%b busy=%b%b s_ren=%b expected 00 11 0",
                         c, grant, m0_if.busy, m1_if.busy, s_if.ren);
            else n_pass++;
            tick();
        end
        clear_inputs();
        nRST = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_if.ren = 1; m0_if.addr = 32'h0000_0010; m0_if.byte_en = 4'hF;
        s_if.rdata = 32'hDEAD_BEEF; s_if.busy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            obs = observe(); exp = model_out(); n_checks++;
            if (obs !== exp)
                $display("FAIL single_read_model c%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if (s_if.ren !== 1'b1 || s_if.addr !== 32'h10 || m0_if.rdata !== 32'hDEAD_BEEF || m0_if.busy !== 1'b0)
                    $display("FAIL single_read_data: got ren=%b addr=%h rdata=%h busy=%b expected 1 10 deadbeef 0",
                             s_if.ren, s_if.addr, m0_if.rdata, m0_if.busy);
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if (grant !== 2'b00 || s_if.ren !== 1'b0)
                    $display("FAIL single_read_idle: got grant=%b s_ren=%b expected 00 0", grant, s_if.ren);
                else n_pass++;
            end
            tick();
            if (c == 1) m0_if.ren = 0;
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [7];
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        do_reset();
        m0_if.ren = 1; m0_if.addr = 32'hA0;
        m1_if.ren = 1; m1_if.addr = 32'hB0;
        s_if.busy = 1'b0; s_if.rdata = 32'h5555_AAAA;
        for (int c = 0; c < 7; c++) begin
            #1;
            obs = observe(); exp = model_out(); n_checks++;
            if (obs !== exp)
                $display("FAIL contention_model c%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            n_checks++;
            if (grant !== exp_g[c])
                $display("FAIL contention_grant c%0d: got %b expected %b", c, grant, exp_g[c]);
            else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_wait_states();
        logic [1:0] exp_g   [7];
        logic       exp_b1  [7];
        logic       exp_b0  [7];
        logic       s_busy  [7];
        exp_g  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        exp_b1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_b0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        s_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            m1_if.wen = (c <= 4); m1_if.addr = 32'h0000_0400;
            m1_if.wdata = 32'hCAFE_F00D; m1_if.byte_en = 4'hF;
            m0_if.ren = (c >= 2); m0_if.addr = 32'h0000_0800;
            s_if.busy = s_busy[c]; s_if.rdata = 32'h0BAD_0000 + 32'(c);
            #1;
            obs = observe(); exp = model_out(); n_checks++;
            if (obs !== exp)
                $display("FAIL wait_model c%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            n_checks++;
            if (grant !== exp_g[c] || m1_if.busy !== exp_b1[c] || m0_if.busy !== exp_b0[c])
                $display("FAIL wait_handshake c%0d: got grant=%b m1_busy=%b m0_busy=%b expected %b %b %b",
                         c, grant, m1_if.busy, m0_if.busy, exp_g[c], exp_b1[c], exp_b0[c]);
            else n_pass++;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_abort();
        logic [1:0] exp_g  [6];
        logic       exp_sr [6];
        exp_g  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
        exp_sr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        m0_if.addr = 32'h44; m1_if.addr = 32'h88;
        for (int c = 0; c < 6; c++) begin
            m0_if.ren = (c != 2) && (c != 5);
            m1_if.ren = (c >= 3) && (c != 5);
            s_if.busy = (c < 3);
            #1;
            obs = observe(); exp = model_out(); n_checks++;
            if (obs !== exp)
                $display("FAIL abort_model c%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            n_checks++;
            if (grant !== exp_g[c] || s_if.ren !== exp_sr[c])
                $display("FAIL abort_seq c%0d: got grant=%b s_ren=%b expected %b %b",
                         c, grant, s_if.ren, exp_g[c], exp_sr[c]);
            else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        m1_if.wen = 1; m1_if.addr = 32'h300; m1_if.wdata = 32'h1357_9BDF; m1_if.byte_en = 4'h3;
        s_if.busy = 1'b1;
        tick();
        #1;
        n_checks++;
        if (grant !== 2'b10 || s_if.wen !== 1'b1)
            $display("FAIL midreset_pre: got grant=%b s_wen=%b expected 10 1", grant, s_if.wen);
        else n_pass++;
        nRST = 1'b0;
        model_reset();
        #1;
        obs = observe(); exp = model_out(); n_checks++;
        if (obs !== exp)
            $display("FAIL midreset_model: got %h expected %h", obs, exp);
        else n_pass++;
        n_checks++;
        if (s_if.wen !== 1'b0 || grant !== 2'b00 || m0_if.busy !== 1'b1 || m1_if.busy !== 1'b1)
            $display("FAIL midreset_drop: got s_wen=%b grant=%b busy=%b%b expected 0 00 11",
                     s_if.wen, grant, m0_if.busy, m1_if.busy);
        else n_pass++;
        tick();
        nRST = 1'b1;
        m0_if.ren = 1; m0_if.addr = 32'h500;
        s_if.busy = 1'b0;
        tick();
        #1;
        obs = observe(); exp = model_out(); n_checks++;
        if (obs !== exp)
            $display("FAIL midreset_after_model: got %h expected %h", obs, exp);
        else n_pass++;
        n_checks++;
        if (grant !== 2'b01)
            $display("FAIL midreset_after_grant: got %b expected 01", grant);
        else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            m0_if.addr = $urandom; m0_if.wdata = $urandom; m0_if.byte_en = 4'($urandom);
            m1_if.addr = $urandom; m1_if.wdata = $urandom; m1_if.byte_en = 4'($urandom);
            s_if.busy = 1'($urandom); s_if.rdata = $urandom;
            #1;
            obs = observe(); exp = model_out(); n_checks++;
            if (obs !== exp)
                $display("FAIL idle_model c%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            n_checks++;
            if (grant !== 2'b00 || s_if.ren !== 1'b0 || s_if.wen !== 1'b0)
                $display("FAIL idle_quiet c%0d: got grant=%b ren=%b wen=%b expected 00 0 0",
                         c, grant, s_if.ren, s_if.wen);
            else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                m0_if.ren = ($urandom_range(0, 99) < 40);
                m0_if.wen = ($urandom_range(0, 99) < 25);
                m0_if.addr = $urandom; m0_if.wdata = $urandom; m0_if.byte_en = 4'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                m1_if.ren = ($urandom_range(0, 99) < 40);
                m1_if.wen = ($urandom_range(0, 99) < 25);
                m1_if.addr = $urandom; m1_if.wdata = $urandom; m1_if.byte_en = 4'($urandom);
            end
            s_if.busy  = ($urandom_range(0, 99) < 40);
            s_if.rdata = $urandom;
            #1;
            obs = observe(); exp = model_out(); n_checks++;
            if (obs !== exp)
                $display("FAIL random_model c%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_wait_states();
        test_abort();
        test_reset_mid_op();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/generic_bus_arbiter.md
GENERIC_BUS_ARBITER -- requirements
Module: generic_bus_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 32, meaning address width of all ports.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 32, meaning width of wdata/rdata (word_t).
REQ-003 CLK  input  1  sole clock, all state on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 m0_addr/m1_addr  input  ADDR_WIDTH  requester address.
REQ-006 m0_ren/m1_ren, m0_wen/m1_wen  input  1 each  requester read/write strobes.
REQ-007 m0_wdata/m1_wdata  input  DATA_WIDTH  requester write data.
REQ-008 m0_byte_en/m1_byte_en  input  4  requester byte enables.
REQ-009 m0_rdata/m1_rdata  output  DATA_WIDTH  read data returned to requester.
REQ-010 m0_busy/m1_busy  output  1  requester stall; 0 means the requester's transaction completes this cycle.
REQ-011 s_addr, s_ren, s_wen, s_wdata, s_byte_en  output  (ADDR_WIDTH, 1, 1, DATA_WIDTH, 4)  forwarded request to the shared generic-bus slave.
REQ-012 s_rdata  input  DATA_WIDTH, s_busy  input  1  slave response.
REQ-013 grant  output  2  one-hot owner indication (bit i = mi granted), for debug/cover.

Function
REQ-014 The block SHALL define req_i = mi_ren | mi_wen.
REQ-015 The block SHALL implement FSM states IDLE, GRANT0, GRANT1, with a 1-bit round-robin pointer rr (value = favoured requester).
REQ-016 In IDLE: s_ren=s_wen=0, s_addr/s_wdata/s_byte_en=0, grant=00, both mi_busy=1.
REQ-017 IDLE transitions: only req_0 -> GRANT0; only req_1 -> GRANT1; both -> GRANTrr; neither -> stay IDLE.
REQ-018 In GRANTi: all s_* request outputs SHALL combinationally equal mi's inputs; mi_rdata=s_rdata; mi_busy=s_busy; other requester's busy=1; grant bit i=1.
REQ-019 Non-granted mi_rdata SHALL be driven 0.
REQ-020 Completion: in GRANTi with req_i=1 and s_busy=0 -> next state IDLE, rr <= ~i.
REQ-021 Abort: in GRANTi with req_i=0 -> next state IDLE, rr unchanged, s_ren/s_wen forwarded as 0 that cycle.
REQ-022 In GRANTi with req_i=1 and s_busy=1 -> stay GRANTi; grant SHALL NOT change mid-transaction regardless of the other requester.
REQ-023 Latency: request seen in IDLE at cycle N reaches slave at N+1; zero-wait slave completes at N+1; IDLE at N+2; next grant earliest at N+3 (one-cycle arbitration bubble is required).
REQ-024 ren and wen both high SHALL be forwarded unchanged; the block does not resolve it.
REQ-025 Address/data changes by the granted requester while s_busy=1 SHALL be forwarded unchanged (requester must hold stable per bus protocol).
REQ-026 No starvation: with both requesting continuously, grants SHALL alternate 0,1,0,1...

Reset
REQ-027 nRST low SHALL asynchronously force state=IDLE, rr=0, hence s_ren=s_wen=0, grant=00, m0_busy=m1_busy=1, all rdata=0.
REQ-028 Reset asserted mid-transaction SHALL drop the slave request immediately; no completion is reported and rr stays 0.
REQ-029 After nRST deasserts, the first arbitration SHALL occur in the first IDLE clock edge.

Verification
REQ-030 Single read: m0_ren=1, addr=0x0000_0010, slave busy=0 returning 0xDEADBEEF -> s_ren=1 next cycle, m0_rdata=0xDEADBEEF with m0_busy=0 that cycle, IDLE after.
REQ-031 Contention: both request at cycle 0 after reset -> GRANT0 at 1, IDLE 2, GRANT1 at 3, IDLE 4, GRANT0 at 5 (alternating).
REQ-032 Wait states: m1 write 0xCAFEF00D, byte_en=0xF, slave busy=1 for 3 cycles -> m1_busy=1 for 3 cycles then 0; m0 request arriving mid-transaction stays busy until after m1 completes.
REQ-033 Abort: m0 granted, slave busy=1, m0 drops ren -> IDLE next cycle, rr still 0, s_ren=0 that cycle.
REQ-034 Reset mid-op: nRST low while GRANT1 with s_busy=1 -> s_wen=0 same cycle, grant=00, both busy=1; after release m0/m1 simultaneous request grants m0.
REQ-035 Idle: no requests for 10 cycles -> s_ren=s_wen=0, grant=00 throughout.
